// File: rtl/ibram_rd_controller.sv
// ibram_rd_controller: read side of the banked input-activation BRAM.
// Takes a {first bank, base address, length} command, issues one read per cycle
// interleaved across the banks, absorbs the BRAM read latency with a
// credit-managed show-ahead FIFO and streams the words out in order.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_base/first_bank/len/valid read command; cmd_ready high only in IDLE
//   addrB, enB                    shared read address, one-hot bank enable
//   doB                           flattened bank read data (bank k at k*STREAM_WIDTH)
//   odata/olast/ovalid/oready     output stream; olast marks a command's final word
//   busy                          high while a command is issuing or draining
module ibram_rd_controller #(
    parameter int unsigned STREAM_WIDTH = 128,
    parameter int unsigned NUM_BANKS    = 16,
    parameter int unsigned IBRAM_DEPTH  = 512,
    parameter int unsigned RD_LATENCY   = 2,
    parameter int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned AW = $clog2(IBRAM_DEPTH),
    localparam int unsigned BW = $clog2(NUM_BANKS),
    localparam int unsigned LW = $clog2(NUM_BANKS * IBRAM_DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [AW-1:0]                     cmd_base,
    input  logic [BW-1:0]                     cmd_first_bank,
    input  logic [LW-1:0]                     cmd_len,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    output logic [AW-1:0]                     addrB,
    output logic [NUM_BANKS-1:0]              enB,
    input  logic [NUM_BANKS*STREAM_WIDTH-1:0] doB,
    output logic [STREAM_WIDTH-1:0]           odata,
    output logic                              olast,
    output logic                              ovalid,
    input  logic                              oready,
    output logic                              busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic                    busy_q;
    logic [AW-1:0]           addr_q, addrB_q;
    logic [BW-1:0]           bank_q;
    logic [LW-1:0]           rem_q;
    logic [NUM_BANKS-1:0]    enB_q;
    logic                    iss_v_q, iss_last_q;
    logic [BW-1:0]           iss_bank_q;
    logic [RD_LATENCY-1:0]   pipe_v_q, pipe_last_q;
    logic [BW-1:0]           pipe_bank_q [RD_LATENCY];
    logic [STREAM_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last_q;
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           fifo_cnt_q;
    // Words issued (including the one on enB this cycle) and not yet popped.
    logic [CW-1:0]           used_q;

    logic                    pop_c, push_c, credit_ok_c, issue_c, last_c;
    logic [CW-1:0]           used_after_pop_c;
    logic [BW-1:0]           cur_bank_c, nxt_bank_c;
    logic [AW-1:0]           cur_addr_c, nxt_addr_c;
    logic [LW-1:0]           cur_rem_c;
    logic [STREAM_WIDTH-1:0] push_data_c;

    function automatic logic [NUM_BANKS-1:0] onehot(input logic [BW-1:0] b);
        onehot    = '0;
        onehot[b] = 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign addrB     = addrB_q;
    assign enB       = enB_q;
    assign busy      = busy_q;
    assign ovalid    = (fifo_cnt_q != '0);
    assign odata     = fifo_data_q[rd_ptr_q];
    assign olast     = fifo_last_q[rd_ptr_q];

    assign pop_c            = ovalid && oready;
    assign push_c           = pipe_v_q[RD_LATENCY-1];
    assign used_after_pop_c = used_q - CW'(pop_c);
    assign credit_ok_c      = used_after_pop_c < CW'(FIFO_DEPTH);

    // Select the read data of the bank whose read completes this cycle.
    always_comb begin
        push_data_c = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (pipe_bank_q[RD_LATENCY-1] == BW'(k)) begin
                push_data_c = doB[k*STREAM_WIDTH +: STREAM_WIDTH];
            end
        end
    end

    // Decide the read for the next cycle; a new command issues word 0 immediately.
    always_comb begin
        issue_c    = 1'b0;
        cur_bank_c = bank_q;
        cur_addr_c = addr_q;
        cur_rem_c  = rem_q;
        if (state_q == IDLE && cmd_valid && cmd_len != '0) begin
            issue_c    = 1'b1;
            cur_bank_c = cmd_first_bank;
            cur_addr_c = cmd_base;
            cur_rem_c  = cmd_len;
        end else if (state_q == ISSUE && credit_ok_c) begin
            issue_c = 1'b1;
        end
        last_c = (cur_rem_c == LW'(1));
        // Address advances only when the bank counter wraps back to bank 0.
        if (cur_bank_c == BW'(NUM_BANKS - 1)) begin
            nxt_bank_c = '0;
            nxt_addr_c = cur_addr_c + AW'(1);
        end else begin
            nxt_bank_c = cur_bank_c + BW'(1);
            nxt_addr_c = cur_addr_c;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue_c) state_d = last_c ? DRAIN : ISSUE;
            ISSUE:   if (issue_c && last_c) state_d = DRAIN;
            DRAIN:   if (used_after_pop_c == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command, issue, read pipeline and FIFO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            addrB_q     <= '0;
            bank_q      <= '0;
            rem_q       <= '0;
            enB_q       <= '0;
            iss_v_q     <= 1'b0;
            iss_last_q  <= 1'b0;
            iss_bank_q  <= '0;
            pipe_v_q    <= '0;
            pipe_last_q <= '0;
            for (int k = 0; k < RD_LATENCY; k++) pipe_bank_q[k] <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) fifo_data_q[k] <= '0;
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            used_q      <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            enB_q   <= issue_c ? onehot(cur_bank_c) : '0;
            if (issue_c) begin
                addrB_q <= cur_addr_c;
                bank_q  <= nxt_bank_c;
                addr_q  <= nxt_addr_c;
                rem_q   <= cur_rem_c - LW'(1);
            end
            iss_v_q    <= issue_c;
            iss_bank_q <= cur_bank_c;
            iss_last_q <= last_c;

            pipe_v_q[0]    <= iss_v_q;
            pipe_last_q[0] <= iss_last_q;
            pipe_bank_q[0] <= iss_bank_q;
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_v_q[k]    <= pipe_v_q[k-1];
                pipe_last_q[k] <= pipe_last_q[k-1];
                pipe_bank_q[k] <= pipe_bank_q[k-1];
            end

            if (push_c) begin
                fifo_data_q[wr_ptr_q] <= push_data_c;
                fifo_last_q[wr_ptr_q] <= pipe_last_q[RD_LATENCY-1];
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
            fifo_cnt_q <= fifo_cnt_q + CW'(push_c) - CW'(pop_c);
            used_q     <= used_after_pop_c + CW'(issue_c);
        end
    end

endmodule

// File: tb/tb_ibram_rd_controller.sv
// Bench for ibram_rd_controller: a 2-cycle-latency banked BRAM model, a
// scoreboard of expected reads and output words derived from the command
// formula, a command table plus backpressure / reset sequences.
module tb_ibram_rd_controller;

    localparam int SW = 128;
    localparam int NB = 16;
    localparam int DEPTH = 512;
    localparam int LAT = 2;
    localparam int FD = 4;
    localparam int AW = 9;
    localparam int BW = 4;
    localparam int LW = 14;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] cmd_base;
    logic [BW-1:0] cmd_first_bank;
    logic [LW-1:0] cmd_len;
    logic cmd_valid, cmd_ready;
    logic [AW-1:0] addrB;
    logic [NB-1:0] enB;
    logic [NB*SW-1:0] doB;
    logic [SW-1:0] odata;
    logic olast, ovalid, oready, busy;

    always #5 clk = ~clk;

    ibram_rd_controller #(
        .STREAM_WIDTH(SW), .NUM_BANKS(NB), .IBRAM_DEPTH(DEPTH),
        .RD_LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_base(cmd_base), .cmd_first_bank(cmd_first_bank), .cmd_len(cmd_len),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .addrB(addrB), .enB(enB), .doB(doB),
        .odata(odata), .olast(olast), .ovalid(ovalid), .oready(oready),
        .busy(busy)
    );

    function automatic logic [SW-1:0] word(input int k, input int a);
        return {8'(k), 16'(a), 8'h5A, 8'(k ^ 5), 16'(a * 3), 8'hC3,
                16'(a), 8'(k), 8'h99, 8'(k + 7), 16'(a ^ 16'h1234), 8'h3C};
    endfunction

    // Banked BRAM model, two-cycle read latency per bank.
    logic [AW-1:0] a1 [NB];
    logic [AW-1:0] a2 [NB];
    always @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (enB[k]) a1[k] <= addrB;
            a2[k] <= a1[k];
        end
    end
    always_comb begin
        doB = '0;
        for (int k = 0; k < NB; k++) doB[k*SW +: SW] = word(k, int'(a2[k]));
    end

    typedef struct { int bank; int addr; } rd_t;
    typedef struct { logic [SW-1:0] data; logic last; } exp_t;
    typedef struct { int base; int fb; int len; int mode; int en_lat; int val_lat; } vec_t;

    rd_t  rd_q [$];
    exp_t out_q [$];
    int cyc, n_vec, n_err;
    int outstanding, n_rd, n_pop, first_en, first_val, last_pop;
    logic hold_prev;
    logic [SW-1:0] prev_data;
    logic prev_last;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle observation of reads and output handshakes, sampled at negedge.
    task automatic monitor();
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (enB != '0) begin
                int b;
                b = 0;
                for (int k = 0; k < NB; k++) if (enB[k]) b = k;
                check("enB_onehot", $countones(enB), 1);
                if (first_en < 0) first_en = cyc;
                n_rd++;
                outstanding++;
                check("outstanding_le_depth", outstanding <= FD, 1);
                check("read_expected", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) begin
                    rd_t r;
                    r = rd_q.pop_front();
                    check("read_bank", b, r.bank);
                    check("read_addr", addrB, r.addr);
                end
            end
            if (hold_prev) begin
                check("hold_ovalid", ovalid, 1);
                check("hold_odata", odata, prev_data);
                check("hold_olast", olast, prev_last);
            end
            if (ovalid && first_val < 0) first_val = cyc;
            if (ovalid && oready) begin
                check("word_expected", out_q.size() != 0, 1);
                if (out_q.size() != 0) begin
                    exp_t e;
                    e = out_q.pop_front();
                    check("odata", odata, e.data);
                    check("olast", olast, e.last);
                end
                n_pop++;
                outstanding--;
                if (olast) last_pop = cyc;
            end
            hold_prev = ovalid && !oready;
            prev_data = odata;
            prev_last = olast;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // mode: 0 oready high, 1 random oready, 2 oready low for cycles T..T+13.
    task automatic run_cmd(input int base, input int fb, input int len, input int mode,
                           input int en_lat, input int val_lat, input int rst_after);
        int t, guard;
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            tick();
            guard++;
        end
        check("cmd_ready_before_cmd", cmd_ready, 1);
        for (int i = 0; i < len; i++) begin
            int bank, addr;
            bank = (fb + i) % NB;
            addr = (base + (fb + i) / NB) % DEPTH;
            rd_q.push_back('{bank, addr});
            out_q.push_back('{word(bank, addr), i == len - 1});
        end
        first_en = -1; first_val = -1; last_pop = -1; n_rd = 0; n_pop = 0;
        cmd_base = AW'(base);
        cmd_first_bank = BW'(fb);
        cmd_len = LW'(len);
        cmd_valid = 1'b1;
        oready = (mode != 2);
        t = cyc;
        tick();
        cmd_valid = 1'b0;
        if (len == 0) begin
            for (int i = 0; i < 4; i++) begin
                check("zero_len_busy", busy, 0);
                check("zero_len_ready", cmd_ready, 1);
                check("zero_len_ovalid", ovalid, 0);
                check("zero_len_enB", enB, 0);
                tick();
            end
            check("zero_len_no_read", first_en, -1);
            return;
        end
        check("busy_after_cmd", busy, 1);
        guard = 0;
        while ((out_q.size() != 0 || !cmd_ready) && guard < 3000) begin
            if (mode == 1) oready = ($urandom_range(0, 3) != 0);
            else if (mode == 2) begin
                if (cyc == t + 14) check("stall_read_count", n_rd, FD);
                oready = (cyc >= t + 14);
            end else oready = 1'b1;
            tick();
            guard++;
            if (rst_after > 0 && n_pop == rst_after) begin
                rst = 1'b1;
                tick();
                check("rst_ovalid", ovalid, 0);
                check("rst_enB", enB, 0);
                check("rst_olast", olast, 0);
                rst = 1'b0;
                rd_q.delete();
                out_q.delete();
                outstanding = 0;
                hold_prev = 1'b0;
                break;
            end
            if (last_pop >= 0 && last_pop == cyc - 1) check("ready_after_last", cmd_ready, 1);
        end
        check("drain_in_time", guard < 3000, 1);
        check("first_enB_latency", first_en - t, en_lat);
        check("first_ovalid_latency", first_val - t, val_lat);
        if (rst_after == 0) check("word_count", n_pop, len);
        if (mode == 0 && rst_after == 0) check("gapless_stream", last_pop - first_val, len - 1);
        oready = 1'b1;
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{0,   0,  4,  0, 1, LAT + 2};
        vecs[1] = '{7,   14, 4,  0, 1, LAT + 2};
        vecs[2] = '{511, 15, 2,  0, 1, LAT + 2};
        vecs[3] = '{100, 5,  37, 1, 1, LAT + 2};
        vecs[4] = '{20,  3,  1,  0, 1, LAT + 2};
        vecs[5] = '{0,   0,  0,  0, -1, -1};

        cyc = 0; n_vec = 0; n_err = 0; outstanding = 0; hold_prev = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_first_bank = '0; cmd_len = '0;
        oready = 1'b1;
        repeat (3) tick();
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_enB", enB, 0);
        check("reset_addrB", addrB, 0);
        check("reset_ovalid", ovalid, 0);
        check("reset_olast", olast, 0);
        check("reset_odata", odata, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        #1;
        check("cmd_ready_after_reset", cmd_ready, 1);

        for (int i = 0; i < 6; i++)
            run_cmd(vecs[i].base, vecs[i].fb, vecs[i].len, vecs[i].mode,
                    vecs[i].en_lat, vecs[i].val_lat, 0);

        // Backpressure: credit limits reads to the FIFO depth while stalled.
        run_cmd(40, 2, 8, 2, 1, LAT + 2, 0);
        // Reset after the 10th word, then a short command must come out clean.
        run_cmd(0, 0, 32, 0, 1, LAT + 2, 10);
        run_cmd(3, 0, 2, 0, 1, LAT + 2, 0);
        repeat (3) tick();
        check("final_idle_busy", busy, 0);
        check("final_no_pending", rd_q.size() + out_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ibram_rd_controller.md
# ibram_rd_controller

Read-side controller for the banked input-activation BRAM (IBRAM) that the input write controller fills from the AXI stream. It accepts a read command (start bank, start address, word count) and issues one-word-per-cycle reads interleaved across the NUM_BANKS banks. It absorbs the fixed BRAM read latency with a credit-managed output FIFO and delivers the words in order on a valid/ready stream to the compute array. Backpressure never drops or duplicates a word.

## Interface
Parameters:
- STREAM_WIDTH, 128, bank word width and output data width
- NUM_BANKS, 16, number of IBRAM banks
- IBRAM_DEPTH, 512, words per bank; power of two
- RD_LATENCY, 2, BRAM read latency in cycles, ≥1
- FIFO_DEPTH, 4, output FIFO entries, ≥RD_LATENCY+1
- AW = $clog2(IBRAM_DEPTH); BW = $clog2(NUM_BANKS); LW = $clog2(NUM_BANKS*IBRAM_DEPTH)+1 (derived)

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_base  in  AW  start address
- cmd_first_bank  in  BW  bank of word 0
- cmd_len  in  LW  number of words
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accept; high only in IDLE
- addrB  out  AW  shared read address to all banks
- enB  out  NUM_BANKS  one-hot bank read enable
- doB  in  NUM_BANKS*STREAM_WIDTH  flattened bank read data; bank k at [k*STREAM_WIDTH +: STREAM_WIDTH]
- odata  out  STREAM_WIDTH  output word
- olast  out  1  marks the final word of a command
- ovalid  out  1  output valid
- oready  in  1  output ready
- busy  out  1  high in ISSUE or DRAIN

## Operation
- Word i of a command is read from bank (cmd_first_bank+i) mod NUM_BANKS. Its address is (cmd_base + (cmd_first_bank+i) div NUM_BANKS) mod IBRAM_DEPTH. In the implementation, the address increments when the bank counter wraps from NUM_BANKS-1 to 0, and the address itself wraps mod IBRAM_DEPTH.
- State machine states: IDLE, ISSUE, DRAIN.
  - IDLE: cmd_ready=1. On cmd_valid with cmd_len≠0, latch the command and go to ISSUE. On cmd_valid with cmd_len=0, accept the command and stay in IDLE; no reads are issued.
  - ISSUE: issue one read per cycle when credit allows. Issuing a read asserts enB for the current bank only and drives addrB, then decrements the remaining count. After the last issue, go to DRAIN.
  - DRAIN: no reads. Go to IDLE once in-flight=0 and the FIFO is empty, i.e. after the olast word has been handshaked.
- Credit rule: a read may issue only when fifo_count + inflight − pop < FIFO_DEPTH, where pop = ovalid&&oready in the same cycle. The FIFO can never overflow.
- Read pipeline: a RD_LATENCY-stage shift register carries {valid, bank, last}. At the final stage, doB[bank] is written into the FIFO together with last.
- The FIFO is show-ahead: odata and olast come from its head, and ovalid = !empty.
- While ovalid && !oready, odata, olast and ovalid hold stable.
- cmd_valid is ignored outside IDLE.

## Timing
- Reset values: state=IDLE, enB=0, addrB=0, ovalid=0, olast=0, odata=0, busy=0, FIFO and pipeline cleared. cmd_ready=0 while rst is high and 1 in the first cycle after rst falls.
- Latency: command handshake in cycle T → first enB in cycle T+1 → first ovalid in cycle T+2+RD_LATENCY (T+4 at default).
- Throughput: with oready held high, enB pulses on every cycle from T+1 to T+cmd_len, and ovalid stays high continuously for cmd_len cycles.
- Back-to-back commands: the next cmd_ready rises in the cycle after the olast handshake.
- Reset mid-operation: in-flight reads are discarded and the FIFO is flushed. The next cycle shows ovalid=0 and enB=0, with no partial olast.
- Simultaneous FIFO push and pop leave fifo_count unchanged. Push and pop are both legal when the FIFO is full-1 or empty+1.

## Test plan
- Basic read: base=0, first_bank=0, len=4, oready=1 → enB = 0x0001, 0x0002, 0x0004, 0x0008 with addrB=0 in cycles T+1..T+4. odata = bank0..bank3 words, in order, in cycles T+4..T+7. olast is high only on the 4th word.
- Bank wrap: base=7, first_bank=14, len=4 → reads at (bank 14, addr 7), (15, 7), (0, 8), (1, 8).
- Address wrap: base=511, first_bank=15, len=2 → reads at (15, 511), then (0, 0).
- Backpressure: len=8, oready low for 10 cycles starting at the first ovalid → at most 4 reads outstanding or buffered, then enB stays 0. After oready rises, all 8 words emerge in order, none lost or duplicated, and olast is on the 8th.
- Zero length: cmd_len=0 handshake → no enB, no ovalid, cmd_ready stays 1, busy stays 0.
- Reset mid-transfer: len=32, rst pulsed after the 10th output word → ovalid=0 and enB=0 the next cycle. A following command (base=3, first_bank=0, len=2) returns bank0@3 then bank1@3 with olast on the second word.
